// File: rtl/echo_pkg.sv
// Shared types and arithmetic for the echo remover.
package echo_pkg;

    localparam int unsigned DATA_W_DEFAULT = 12;
    localparam int unsigned MAX_W          = 32;

    typedef logic [DATA_W_DEFAULT-1:0] sample_t;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } fsm_t;

    // y - (d >> 1) at MAX_W bits. Callers zero-extend their operands and keep the
    // low bits of the result, which yields the correct modular result at any
    // narrower width.
    function automatic logic [MAX_W-1:0] half_sub(input logic [MAX_W-1:0] y,
                                                   input logic [MAX_W-1:0] d);
        return y - (d >> 1);
    endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Simple dual-port delay-line RAM: one synchronous write port and one synchronous
// read port with 1-cycle latency. Contents are not reset.
module echo_delay_ram #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port, registered
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/echo_remover.sv
// Echo remover: x[n] = y[n] - (x[n-DELAY] >> 1), with the output fed back into a
// circular delay line. Two-stage pipeline: S0 captures the sample and reads the
// delay line; S1 computes, writes back and registers the output.
module echo_remover #(
    parameter int unsigned DATA_W = echo_pkg::DATA_W_DEFAULT,
    parameter int unsigned DELAY  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] SignalIn,
    output logic [DATA_W-1:0] SignalOut,
    output logic              out_valid,
    output logic              primed
);

    import echo_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DELAY - 1);

    fsm_t              state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] fill_cnt;
    logic [DATA_W-1:0] y_r;
    logic              en_r;
    logic              prm_r;
    logic              s0_valid;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] echo_c;
    logic [DATA_W-1:0] x_c;
    logic              accept_c;

    // A sample is accepted only when no flush is pending in the same cycle
    assign accept_c = sample_valid & ~flush;

    // S0 capture, write pointer and priming FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PRIME;
            primed   <= 1'b0;
            wr_ptr   <= '0;
            wr_ptr_r <= '0;
            fill_cnt <= '0;
            y_r      <= '0;
            en_r     <= 1'b0;
            prm_r    <= 1'b0;
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= accept_c;
            if (flush) begin
                state    <= PRIME;
                primed   <= 1'b0;
                wr_ptr   <= '0;
                fill_cnt <= '0;
            end else if (sample_valid) begin
                y_r      <= SignalIn;
                en_r     <= en;
                wr_ptr_r <= wr_ptr;
                prm_r    <= (state == RUN);
                wr_ptr   <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_W'(1);
                if (state == PRIME) begin
                    if (fill_cnt == LAST) begin
                        state  <= RUN;
                        primed <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + ADDR_W'(1);
                    end
                end
            end
        end
    end

    // S1 arithmetic; the echo term is masked while the line is still filling
    always_comb begin
        echo_c = prm_r ? rd_data : '0;
        x_c    = en_r ? DATA_W'(half_sub(MAX_W'(y_r), MAX_W'(echo_c))) : y_r;
    end

    // S1 output register and one-cycle valid strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SignalOut <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s0_valid;
            if (s0_valid) begin
                SignalOut <= x_c;
            end
        end
    end

    // Write address trails the read address by one, so the ports never collide
    echo_delay_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DELAY),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (s0_valid),
        .wr_addr (wr_ptr_r),
        .wr_data (x_c),
        .rd_en   (accept_c),
        .rd_addr (wr_ptr),
        .rd_data (rd_data)
    );

endmodule
